// File: rtl/clock_pkg.sv
// Shared constants and types for the clock datapath (tick divider and timekeeper).
package clock_pkg;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEC_TENS_W = 3;
  localparam int unsigned MIN_TENS_W = 3;
  localparam int unsigned HR_TENS_W  = 2;

  localparam int unsigned SEC_MAX    = 59;
  localparam int unsigned MIN_MAX    = 59;
  localparam int unsigned HR24_MIN   = 0;
  localparam int unsigned HR24_MAX   = 23;
  localparam int unsigned HR12_MIN   = 1;
  localparam int unsigned HR12_MAX   = 12;
  localparam int unsigned HR12_PM_AT = 11;

  typedef logic [BCD_W-1:0]      bcd_t;
  typedef logic [SEC_TENS_W-1:0] sec_tens_t;
  typedef logic [MIN_TENS_W-1:0] min_tens_t;
  typedef logic [HR_TENS_W-1:0]  hr_tens_t;

  // Count enable from the 1 Hz divider: high for exactly one clk cycle per second.
  typedef logic tick_t;
endpackage

// File: rtl/clock_timekeeper_if.sv
// Control inputs and BCD time outputs of the timekeeper, grouped as one bundle.
interface clock_timekeeper_if;
  import clock_pkg::*;

  tick_t     tick;
  logic      set_en;
  logic      inc_hr;
  logic      inc_min;
  logic      clr_sec;
  bcd_t      sec_ones;
  sec_tens_t sec_tens;
  bcd_t      min_ones;
  min_tens_t min_tens;
  bcd_t      hr_ones;
  hr_tens_t  hr_tens;
  logic      pm;
  logic      pulse_min;
  logic      pulse_day;

  modport master (
    output tick, set_en, inc_hr, inc_min, clr_sec,
    input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
    input  pm, pulse_min, pulse_day
  );

  modport slave (
    input  tick, set_en, inc_hr, inc_min, clr_sec,
    output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
    output pm, pulse_min, pulse_day
  );
endinterface

// File: rtl/clock_timekeeper_bcd_mod_counter.sv
// Two-digit BCD modulo counter: MAX_VAL wraps to WRAP_VAL, optional AM/PM flag
// that toggles when stepping off TOG_VAL with tog_en_i set.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned TENS_W   = 3,
  parameter int unsigned MAX_VAL  = 59,
  parameter int unsigned WRAP_VAL = 0,
  parameter int unsigned RST_VAL  = 0,
  parameter int unsigned TOG_VAL  = 0,
  parameter bit          PM_EN    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              clr_i,
  input  logic              tog_en_i,
  output bcd_t              ones_o,
  output logic [TENS_W-1:0] tens_o,
  output logic              at_max_o,
  output logic              pm_o
);
  typedef logic [TENS_W-1:0] tens_t;

  localparam bcd_t  MAX_O  = bcd_t'(MAX_VAL % 10);
  localparam tens_t MAX_T  = tens_t'(MAX_VAL / 10);
  localparam bcd_t  WRAP_O = bcd_t'(WRAP_VAL % 10);
  localparam tens_t WRAP_T = tens_t'(WRAP_VAL / 10);
  localparam bcd_t  RST_O  = bcd_t'(RST_VAL % 10);
  localparam tens_t RST_T  = tens_t'(RST_VAL / 10);
  localparam bcd_t  TOG_O  = bcd_t'(TOG_VAL % 10);
  localparam tens_t TOG_T  = tens_t'(TOG_VAL / 10);

  bcd_t  ones_q, ones_d;
  tens_t tens_q, tens_d;
  logic  pm_q, pm_d;
  logic  at_max, at_tog;

  assign at_max = (tens_q == MAX_T) && (ones_q == MAX_O);
  assign at_tog = (tens_q == TOG_T) && (ones_q == TOG_O);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    pm_d   = pm_q;
    if (clr_i) begin
      ones_d = WRAP_O;
      tens_d = WRAP_T;
    end else if (inc_i) begin
      if (at_max) begin
        ones_d = WRAP_O;
        tens_d = WRAP_T;
      end else if (ones_q == bcd_t'(9)) begin
        ones_d = '0;
        tens_d = tens_q + tens_t'(1);
      end else begin
        ones_d = ones_q + bcd_t'(1);
      end
      if (PM_EN && tog_en_i && at_tog) pm_d = ~pm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= RST_O;
      tens_q <= RST_T;
      pm_q   <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      pm_q   <= pm_d;
    end
  end

  assign ones_o   = ones_q;
  assign tens_o   = tens_q;
  assign at_max_o = at_max;
  assign pm_o     = pm_q;
endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day core: BCD HH:MM:SS advanced by the 1 Hz tick, with a set mode
// for hours/minutes and one-cycle minute/day rollover pulses.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter bit HOURS_24 = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  clock_timekeeper_if.slave  tk
);
  localparam int unsigned HR_MAX  = HOURS_24 ? HR24_MAX : HR12_MAX;
  localparam int unsigned HR_WRAP = HOURS_24 ? HR24_MIN : HR12_MIN;
  localparam int unsigned HR_RST  = HOURS_24 ? HR24_MIN : HR12_MAX;

  logic run_tick;
  logic sec_inc, sec_clr, min_inc, hr_inc;
  logic sec_at_max, min_at_max, hr_at_max;
  logic hr_half;
  logic sec_pm, min_pm, hr_pm;
  logic unused_pm;
  logic pulse_min_q, pulse_min_d;
  logic pulse_day_q, pulse_day_d;

  // set_en sampled this cycle decides the mode; tick never leaks into set mode.
  assign run_tick = tk.tick & ~tk.set_en;
  assign sec_inc  = run_tick;
  assign sec_clr  = tk.set_en & tk.clr_sec;
  assign min_inc  = (run_tick & sec_at_max) | (tk.set_en & tk.inc_min);
  assign hr_inc   = (run_tick & sec_at_max & min_at_max) | (tk.set_en & tk.inc_hr);
  assign hr_half  = (tk.hr_tens == hr_tens_t'(HR12_PM_AT / 10)) &&
                    (tk.hr_ones == bcd_t'(HR12_PM_AT % 10));

  bcd_mod_counter #(
    .TENS_W  (SEC_TENS_W),
    .MAX_VAL (SEC_MAX),
    .WRAP_VAL(0),
    .RST_VAL (0),
    .TOG_VAL (0),
    .PM_EN   (1'b0)
  ) u_sec (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (sec_inc),
    .clr_i   (sec_clr),
    .tog_en_i(1'b0),
    .ones_o  (tk.sec_ones),
    .tens_o  (tk.sec_tens),
    .at_max_o(sec_at_max),
    .pm_o    (sec_pm)
  );

  bcd_mod_counter #(
    .TENS_W  (MIN_TENS_W),
    .MAX_VAL (MIN_MAX),
    .WRAP_VAL(0),
    .RST_VAL (0),
    .TOG_VAL (0),
    .PM_EN   (1'b0)
  ) u_min (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (min_inc),
    .clr_i   (1'b0),
    .tog_en_i(1'b0),
    .ones_o  (tk.min_ones),
    .tens_o  (tk.min_tens),
    .at_max_o(min_at_max),
    .pm_o    (min_pm)
  );

  // pm toggles only on a tick-driven 11->12 step, never on a set-mode increment.
  bcd_mod_counter #(
    .TENS_W  (HR_TENS_W),
    .MAX_VAL (HR_MAX),
    .WRAP_VAL(HR_WRAP),
    .RST_VAL (HR_RST),
    .TOG_VAL (HR12_PM_AT),
    .PM_EN   (!HOURS_24)
  ) u_hr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hr_inc),
    .clr_i   (1'b0),
    .tog_en_i(run_tick),
    .ones_o  (tk.hr_ones),
    .tens_o  (tk.hr_tens),
    .at_max_o(hr_at_max),
    .pm_o    (hr_pm)
  );

  assign unused_pm = sec_pm ^ min_pm;

  always_comb begin
    pulse_min_d = run_tick & sec_at_max;
    pulse_day_d = run_tick & sec_at_max & min_at_max & (HOURS_24 ? hr_at_max : hr_half);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_min_q <= 1'b0;
      pulse_day_q <= 1'b0;
    end else begin
      pulse_min_q <= pulse_min_d;
      pulse_day_q <= pulse_day_d;
    end
  end

  assign tk.pm        = HOURS_24 ? 1'b0 : hr_pm;
  assign tk.pulse_min = pulse_min_q;
  assign tk.pulse_day = pulse_day_q;
endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper: a 24h and a 12h instance share one stimulus stream,
// checked every cycle against an integer time model plus table end-point checks.
module tb_clock_timekeeper;
  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  clock_timekeeper_if a_if ();
  clock_timekeeper_if b_if ();

  clock_timekeeper #(.HOURS_24(1'b1)) dut_a (.clk(clk), .rst(rst), .tk(a_if));
  clock_timekeeper #(.HOURS_24(1'b0)) dut_b (.clk(clk), .rst(rst), .tk(b_if));

  typedef struct {
    int s, m, h24, h12;
    bit pm, pmin, pday24, pday12;
  } exp_t;

  // flags = {rst, tick, set_en, inc_hr, inc_min, clr_sec, gap}
  typedef struct {
    bit [6:0] flags;
    int reps;
    int hh, mm, ss;
    int npmin, npday;
  } vec_t;

  exp_t sb[$];
  vec_t vt[20];
  int   errors = 0;
  int   checks = 0;
  int   cnt_pmin, cnt_pday;
  int   ms, mm, mh24, mh12;
  bit   mpm;
  logic se_r = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int a_time();
    return (int'(a_if.hr_tens) * 10 + int'(a_if.hr_ones)) * 10000 +
           (int'(a_if.min_tens) * 10 + int'(a_if.min_ones)) * 100 +
           (int'(a_if.sec_tens) * 10 + int'(a_if.sec_ones));
  endfunction

  function automatic int b_time();
    return (int'(b_if.hr_tens) * 10 + int'(b_if.hr_ones)) * 10000 +
           (int'(b_if.min_tens) * 10 + int'(b_if.min_ones)) * 100 +
           (int'(b_if.sec_tens) * 10 + int'(b_if.sec_ones));
  endfunction

  task automatic model_step(input logic r, t, se, ih, im, cs, output exp_t e);
    e.pmin = 0; e.pday24 = 0; e.pday12 = 0;
    if (r) begin
      ms = 0; mm = 0; mh24 = 0; mh12 = 12; mpm = 0;
    end else if (!se) begin
      if (t) begin
        if (ms == 59) begin
          e.pmin = 1;
          ms = 0;
          if (mm == 59) begin
            mm = 0;
            e.pday24 = (mh24 == 23);
            e.pday12 = (mh12 == 11);
            mh24 = (mh24 + 1) % 24;
            if (mh12 == 11) mpm = ~mpm;
            mh12 = (mh12 % 12) + 1;
          end else mm++;
        end else ms++;
      end
    end else begin
      if (cs) ms = 0;
      if (im) mm = (mm + 1) % 60;
      if (ih) begin
        mh24 = (mh24 + 1) % 24;
        mh12 = (mh12 % 12) + 1;
      end
    end
    e.s = ms; e.m = mm; e.h24 = mh24; e.h12 = mh12; e.pm = mpm;
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("a_time", a_time(), e.h24 * 10000 + e.m * 100 + e.s);
    chk("a_pm", int'(a_if.pm), 0);
    chk("a_pulse_min", int'(a_if.pulse_min), int'(e.pmin));
    chk("a_pulse_day", int'(a_if.pulse_day), int'(e.pday24));
    chk("b_time", b_time(), e.h12 * 10000 + e.m * 100 + e.s);
    chk("b_pm", int'(b_if.pm), int'(e.pm));
    chk("b_pulse_min", int'(b_if.pulse_min), int'(e.pmin));
    chk("b_pulse_day", int'(b_if.pulse_day), int'(e.pday12));
    cnt_pmin += int'(a_if.pulse_min);
    cnt_pday += int'(a_if.pulse_day);
  endtask

  task automatic step(input logic r, t, se, ih, im, cs);
    exp_t e;
    rst = r;
    a_if.tick = t;  a_if.set_en = se; a_if.inc_hr = ih; a_if.inc_min = im; a_if.clr_sec = cs;
    b_if.tick = t;  b_if.set_en = se; b_if.inc_hr = ih; b_if.inc_min = im; b_if.clr_sec = cs;
    model_step(r, t, se, ih, im, cs, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{7'b1000000,  2,  0,  0,  0, 0, 0};
    vt[1]  = '{7'b0100001, 10,  0,  0, 10, 0, 0};
    vt[2]  = '{7'b0011001, 23, 23,  0, 10, 0, 0};
    vt[3]  = '{7'b0010101, 59, 23, 59, 10, 0, 0};
    vt[4]  = '{7'b0010010,  1, 23, 59,  0, 0, 0};
    vt[5]  = '{7'b0100000, 59, 23, 59, 59, 0, 0};
    vt[6]  = '{7'b0100000,  1,  0,  0,  0, 1, 1};
    vt[7]  = '{7'b0000000,  1,  0,  0,  0, 0, 0};
    vt[8]  = '{7'b0010101, 59,  0, 59,  0, 0, 0};
    vt[9]  = '{7'b0100000, 30,  0, 59, 30, 0, 0};
    vt[10] = '{7'b0110000,  5,  0, 59, 30, 0, 0};
    vt[11] = '{7'b0010100,  1,  0,  0, 30, 0, 0};
    vt[12] = '{7'b0011010,  1,  1,  0,  0, 0, 0};
    vt[13] = '{7'b0011001, 11, 12,  0,  0, 0, 0};
    vt[14] = '{7'b0010101, 34, 12, 34,  0, 0, 0};
    vt[15] = '{7'b0100000, 56, 12, 34, 56, 0, 0};
    vt[16] = '{7'b1100000,  1,  0,  0,  0, 0, 0};
    vt[17] = '{7'b0100000, 65,  0,  1,  5, 1, 0};
    vt[18] = '{7'b0111110,  1,  1,  2,  0, 0, 0};
    vt[19] = '{7'b1011100,  1,  0,  0,  0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      bit [6:0] f;
      f = vt[i].flags;
      cnt_pmin = 0;
      cnt_pday = 0;
      for (int k = 0; k < vt[i].reps; k++) begin
        step(f[6], f[5], f[4], f[3], f[2], f[1]);
        if (f[0]) step(1'b0, 1'b0, f[4], 1'b0, 1'b0, 1'b0);
      end
      chk($sformatf("row%0d_time", i), a_time(), vt[i].hh * 10000 + vt[i].mm * 100 + vt[i].ss);
      chk($sformatf("row%0d_pulse_min_count", i), cnt_pmin, vt[i].npmin);
      chk($sformatf("row%0d_pulse_day_count", i), cnt_pday, vt[i].npday);
    end

    // Half-day rollovers in 12h mode: AM->PM at noon, then PM->AM at midnight.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_reset_time", b_time(), 120000);
    chk("b_reset_pm", int'(b_if.pm), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("b_set_hr_wrap", b_time(), 10000);
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (59) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (59) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_before_noon", b_time(), 115959);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_noon_time", b_time(), 120000);
    chk("b_noon_pm", int'(b_if.pm), 1);
    chk("b_noon_pulse_day", int'(b_if.pulse_day), 1);
    chk("a_noon_no_pulse_day", int'(a_if.pulse_day), 0);
    repeat (11) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("b_set_no_pm_toggle", int'(b_if.pm), 1);
    repeat (59) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (59) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_midnight_time", b_time(), 120000);
    chk("b_midnight_pm", int'(b_if.pm), 0);
    chk("a_midnight_time", a_time(), 0);
    chk("a_midnight_pulse_day", int'(a_if.pulse_day), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a_pulse_day_drop", int'(a_if.pulse_day), 0);

    // Mixed random traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 24) == 0) se_r = ~se_r;
      step($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, se_r,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Time-of-day core of the digital clock.
- Sits directly downstream of the 50 MHz to 1 Hz tick divider and consumes its one-cycle tick as a count enable.
- Keeps HH:MM:SS as BCD digits for the display/LED stage.
- Provides a set mode for adjusting hours and minutes, and rollover pulses for downstream alarm/date logic.

Parameters:
- HOURS_24, 1: 1 = 00..23 hour range; 0 = 12-hour mode, hours 01..12 with AM/PM flag.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clk-cycle count enable from the 1 Hz divider
- set_en  in  1  level; 1 = adjust mode, time frozen
- inc_hr  in  1  one-cycle pulse; +1 hour, honoured only while set_en=1
- inc_min  in  1  one-cycle pulse; +1 minute, honoured only while set_en=1
- clr_sec  in  1  one-cycle pulse; seconds to 00, honoured only while set_en=1
- sec_ones  out  4  BCD 0..9
- sec_tens  out  3  0..5
- min_ones  out  4  BCD 0..9
- min_tens  out  3  0..5
- hr_ones  out  4  BCD 0..9
- hr_tens  out  2  0..2
- pm  out  1  12-hour mode only; tied 0 when HOURS_24=1
- pulse_min  out  1  one-cycle pulse on seconds 59->00 rollover
- pulse_day  out  1  one-cycle pulse on day (24h) or half-day (12h) rollover

Behaviour:
- One clock (clk); reset is synchronous and active-high on rst. All outputs are registered.
- Reset:
  - HOURS_24=1: time 00:00:00.
  - HOURS_24=0: time 12:00:00, pm=0.
  - Both modes: pulse_min=0, pulse_day=0.
  - rst overrides every other input in the same cycle, including mid-rollover or mid-set.
- Latency: an input sampled at edge N is reflected on the outputs after edge N; one cycle, no pipelining.
- Run mode (set_en=0):
  - Each cycle with tick=1 adds one second.
  - The carry chain sec -> min -> hr resolves within that single cycle.
  - tick held high for k cycles advances time by k seconds; there is no edge detection.
  - inc_hr, inc_min and clr_sec are ignored.
- Digit rules:
  - ones digit wraps 9->0 and carries into tens.
  - sec/min tens wrap 5->0 and carry out.
  - HOURS_24=1: hours 23->00.
  - HOURS_24=0: hours 12->01; the 11->12 transition toggles pm.
- Pulses:
  - pulse_min is high for exactly the one cycle in which the outputs first show seconds=00 after a tick-driven rollover.
  - pulse_day is high for exactly the one cycle in which the outputs first show 00:00:00 (24h), or 12:00:00 after 11:59:59 (12h).
  - Both pulses are 0 in every other cycle.
- Set mode (set_en=1):
  - tick is ignored and seconds freeze.
  - inc_min: minutes +1, 59->00, no carry into hours.
  - inc_hr: hours +1, wrapping per mode, no pm toggle and no carry.
  - clr_sec: seconds -> 00.
  - Simultaneous inc_hr, inc_min and clr_sec in one cycle: all three apply.
  - pulse_min and pulse_day are never asserted in set mode.
- set_en falling with tick=1 in the same cycle: the set_en value sampled that cycle governs, so tick is ignored.
- Internal state is always legal BCD; there is no external load path.

Decomposition:
- Shared package clock_pkg holds:
  - BCD digit width constants
  - SEC_MAX/MIN_MAX = 59
  - HR24_MAX = 23, HR12_MIN = 1, HR12_MAX = 12
  - the shared tick-enable contract (one-cycle pulse)
  The tick divider uses the same package.
- One natural sub-module: bcd_mod_counter.
  - Function: two-digit BCD counter with enable, parameterised min/max, wrap value and carry-out.
  - Instantiated three times (sec, min, hr); the hr instance also handles the pm toggle.

Test Plan:
- rst for 2 cycles, then 10 single-cycle ticks -> 00:00:10; pulse_min never high.
- set_en=1; inc_hr x23; inc_min x59; set_en=0; 59 ticks -> 23:59:59. Next tick -> 00:00:00 with pulse_min=1 and pulse_day=1 for exactly one cycle, both 0 the cycle after.
- set_en=1 at 00:59:30:
  - tick pulses -> no change.
  - inc_min -> 00:00:30 with hours unchanged and no pulses.
  - clr_sec together with inc_hr -> 01:00:00.
- At 12:34:56, assert rst in the same cycle as tick -> 00:00:00 next cycle, pulses 0.
- tick held high for 65 consecutive cycles from 00:00:00 -> 00:01:05; pulse_min high in exactly one cycle.
- HOURS_24=0:
  - reset -> 12:00:00, pm=0.
  - inc_hr -> 01.
  - Run from 11:59:59 with one tick -> 12:00:00, pm=1, pulse_day=1 for one cycle.
